// File: rtl/mavg_window_dump.sv
`default_nettype none
// ============================================================================
// Module   : mavg_window_dump
// Brief    : Ring-buffers the x_N stream and, on request, streams the most
//            recent full window oldest-first over a ready/valid port.
// Revision : 1.0
// ============================================================================
module mavg_window_dump #(
    parameter int WIND_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_N,
    input  logic                  x_N_valid,
    output logic                  window_valid,
    input  logic                  dump_req,
    output logic                  dump_busy,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [15:0]           drop_cnt
);

    localparam int DEPTH = 2 ** WIND_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    localparam logic [WIND_WIDTH-1:0] c_ADDR_MAX = {WIND_WIDTH{1'b1}};
    localparam logic [15:0]           c_DROP_MAX = 16'hFFFF;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [WIND_WIDTH-1:0] r_wr_addr;
    logic [WIND_WIDTH-1:0] r_rd_addr;
    logic [WIND_WIDTH-1:0] r_beat;
    logic                  r_window_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_m_valid;
    logic                  w_m_valid_nxt;
    logic [15:0]           r_drop_cnt;

    logic w_wr_en;
    logic w_accept;
    logic w_handshake;
    logic w_last;
    logic w_rd_en;

    assign dump_busy    = (r_state != S_IDLE);
    assign window_valid = r_window_valid;
    assign m_valid      = r_m_valid;
    assign m_data       = r_rd_data;
    assign m_last       = w_last;
    assign drop_cnt     = r_drop_cnt;

    always_comb begin
        w_wr_en     = x_N_valid && (r_state == S_IDLE);
        w_accept    = (r_state == S_IDLE) && dump_req && r_window_valid;
        w_handshake = r_m_valid && m_ready;
        w_last      = r_m_valid && (r_beat == c_ADDR_MAX);
    end

    // Next-state and read-issue decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_en       = 1'b0;
        w_m_valid_nxt = r_m_valid;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                w_rd_en       = 1'b1;
                w_m_valid_nxt = 1'b1;
                w_state_nxt   = S_STREAM;
            end
            S_STREAM: begin
                if (w_handshake) begin
                    if (w_last) begin
                        w_m_valid_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_rd_en = 1'b1;
                    end
                end
            end
            default: begin
                w_m_valid_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_m_valid <= w_m_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= x_N;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_addr      <= '0;
            r_window_valid <= 1'b0;
            r_rd_addr      <= '0;
            r_beat         <= '0;
            r_rd_data      <= '0;
            r_drop_cnt     <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + 1'b1;
                if (r_wr_addr == c_ADDR_MAX) begin
                    r_window_valid <= 1'b1;
                end
            end

            // A sample written in the accept cycle becomes the newest entry,
            // so the oldest entry sits just past it.
            if (w_accept) begin
                r_rd_addr  <= w_wr_en ? (r_wr_addr + 1'b1) : r_wr_addr;
                r_beat     <= '0;
                r_drop_cnt <= '0;
            end else if (dump_busy && x_N_valid && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end

            if (w_rd_en) begin
                r_rd_data <= r_mem[r_rd_addr];
                r_rd_addr <= r_rd_addr + 1'b1;
            end

            if (w_handshake && !w_last) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mavg_window_dump.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mavg_window_dump
// Brief    : Randomized self-checking bench against a sample-history model.
// Revision : 1.0
// ============================================================================
module tb_mavg_window_dump;

    localparam int WW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] x_N;
    logic          x_N_valid;
    logic          window_valid;
    logic          dump_req;
    logic          dump_busy;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [15:0]   drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Every sample the design accepted since reset, oldest first.
    logic [DW-1:0] hist[$];

    always #5 clk = ~clk;

    mavg_window_dump #(.WIND_WIDTH(WW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .x_N         (x_N),
        .x_N_valid   (x_N_valid),
        .window_valid(window_valid),
        .dump_req    (dump_req),
        .dump_busy   (dump_busy),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .drop_cnt    (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input logic [DW-1:0] v);
        x_N       = v;
        x_N_valid = 1'b1;
        tick();
        x_N_valid = 1'b0;
        hist.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if (window_valid !== 1'b0 || dump_busy !== 1'b0 || m_valid !== 1'b0 ||
            m_last !== 1'b0 || m_data !== '0 || drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL %s: wv=%b busy=%b mv=%b ml=%b md=%h drop=%0d, required all zero",
                     tag, window_valid, dump_busy, m_valid, m_last, m_data, drop_cnt);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        hist.delete();
    endtask

    // Accept a dump (optionally with a coincident sample), stream it, and
    // offer n_drop samples during the dump that must be discarded.
    task automatic run_dump(input bit rnd_ready, input bit acc_wr,
                            input logic [DW-1:0] acc_val, input int n_drop);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] held_data;
        logic          held_last;
        logic          exp_last;
        bit            held;
        int            beat;
        int            cyc;
        int            first_cyc;

        if (acc_wr) hist.push_back(acc_val);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(hist[hist.size() - DEPTH + i]);

        dump_req  = 1'b1;
        x_N       = acc_val;
        x_N_valid = acc_wr;
        tick();
        dump_req  = 1'b0;
        x_N_valid = 1'b0;

        n_cmp++;
        if (dump_busy !== 1'b1 || drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL accept: busy=%b drop=%0d, required busy=1 drop=0", dump_busy, drop_cnt);
        end

        beat      = 0;
        cyc       = 0;
        first_cyc = -1;
        held      = 0;
        held_data = '0;
        held_last = 1'b0;
        while (beat < DEPTH && cyc < 400) begin
            if (held) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== held_data || m_last !== held_last) begin
                    n_err++;
                    $display("FAIL hold_stable: mv=%b md=%h ml=%b, required mv=1 md=%h ml=%b",
                             m_valid, m_data, m_last, held_data, held_last);
                end
            end
            m_ready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            x_N       = DW'($urandom);
            x_N_valid = (cyc < n_drop);
            if (m_valid === 1'b1) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    n_cmp++;
                    if (cyc != 1) begin
                        n_err++;
                        $display("FAIL first_valid: at accept+%0d, required accept+2", cyc + 1);
                    end
                end
                exp_last = (beat == DEPTH - 1);
                n_cmp++;
                if (m_last !== exp_last) begin
                    n_err++;
                    $display("FAIL m_last: beat %0d got %b, required %b", beat, m_last, exp_last);
                end
                if (m_ready) begin
                    n_cmp++;
                    if (m_data !== exp_q[beat]) begin
                        n_err++;
                        $display("FAIL beat_data: beat %0d got %h, required %h", beat, m_data, exp_q[beat]);
                    end
                    if (exp_last && !rnd_ready) begin
                        n_cmp++;
                        if (cyc != DEPTH) begin
                            n_err++;
                            $display("FAIL last_timing: at accept+%0d, required accept+%0d", cyc + 1, DEPTH + 1);
                        end
                    end
                    beat++;
                    held = 0;
                end else begin
                    held      = 1;
                    held_data = m_data;
                    held_last = m_last;
                end
            end
            tick();
            cyc++;
        end
        x_N_valid = 1'b0;
        m_ready   = 1'b1;

        if (beat < DEPTH) begin
            n_cmp++;
            n_err++;
            $display("FAIL dump_timeout: got %0d beats, required %0d", beat, DEPTH);
        end
        n_cmp++;
        if (dump_busy !== 1'b0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dump_end: busy=%b mv=%b, required 0 0", dump_busy, m_valid);
        end
        n_cmp++;
        if (drop_cnt !== 16'(n_drop)) begin
            n_err++;
            $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, n_drop);
        end
        tick();
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL extra_beat: mv=%b, required 0", m_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset_state");
    endtask

    task automatic test_window_fill();
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) write_sample(DW'($urandom));
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (dump_busy !== 1'b0 || m_valid !== 1'b0 || window_valid !== 1'b0) begin
                n_err++;
                $display("FAIL early_req: busy=%b mv=%b wv=%b, required 0 0 0",
                         dump_busy, m_valid, window_valid);
            end
            tick();
        end
        write_sample(DW'($urandom));
        n_cmp++;
        if (window_valid !== 1'b1) begin
            n_err++;
            $display("FAIL window_valid: got %b, required 1", window_valid);
        end
    endtask

    task automatic test_basic_dump();
        do_reset();
        for (int i = 1; i <= 20; i++) write_sample(DW'(i));
        run_dump(0, 0, '0, 0);
    endtask

    task automatic test_accept_write();
        do_reset();
        for (int i = 1; i <= 16; i++) write_sample(DW'(i));
        run_dump(0, 1, DW'(17), 0);
    endtask

    task automatic test_drop();
        do_reset();
        for (int i = 0; i < 18; i++) write_sample(DW'($urandom));
        run_dump(0, 0, '0, 5);
        tick();
        n_cmp++;
        if (drop_cnt !== 16'd5) begin
            n_err++;
            $display("FAIL drop_hold: got %0d, required 5", drop_cnt);
        end
        run_dump(1, 0, '0, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) write_sample(DW'($urandom));
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < d * 3; i++) write_sample(DW'($urandom));
            run_dump(1, d == 1, DW'($urandom), 0);
        end
    endtask

    task automatic test_reset_mid_dump();
        int beats;
        int cyc;
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_sample(DW'($urandom));
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        m_ready  = 1'b1;
        beats    = 0;
        cyc      = 0;
        while (beats < 7 && cyc < 100) begin
            if (m_valid === 1'b1) beats++;
            tick();
            cyc++;
        end
        n_cmp++;
        if (m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_dump_beat: mv=%b at 8th beat, required 1", m_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hist.delete();
        check_reset_values("reset_mid_dump");
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (m_valid !== 1'b0 || dump_busy !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_quiet: mv=%b busy=%b, required 0 0", m_valid, dump_busy);
            end
        end
        for (int i = 0; i < DEPTH; i++) write_sample(DW'($urandom));
        run_dump(1, 0, '0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        x_N       = '0;
        x_N_valid = 1'b0;
        dump_req  = 1'b0;
        m_ready   = 1'b1;

        test_reset();
        test_window_fill();
        test_basic_dump();
        test_accept_write();
        test_drop();
        test_back_to_back();
        test_reset_mid_dump();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mavg_window_dump.md
# mavg_window_dump

Read-side companion to the moving-average filter's sample ring buffer. Captures the incoming x_N sample stream into a 2^WIND_WIDTH-deep ring RAM, with the same write pointer and window-fill rules as the filter. On request, it streams the most recent full window out oldest-first over a ready/valid interface. Used for debug and coefficient-free post-processing of the exact window the averager is summing.

## Interface
- WIND_WIDTH, 4: log2 of window depth; DEPTH = 2^WIND_WIDTH.
- DATA_WIDTH, 16: sample width.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- x_N  in  DATA_WIDTH  input sample.
- x_N_valid  in  1  sample strobe; one sample per asserted cycle.
- window_valid  out  1  sticky; set once DEPTH samples have been written since reset.
- dump_req  in  1  single-cycle request to stream the current window.
- dump_busy  out  1  dump in progress.
- m_data  out  DATA_WIDTH  streamed sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  marks the final (DEPTH-th) beat of a dump.
- drop_cnt  out  16  samples discarded during the current or last dump; saturates at 0xFFFF.

## Operation
- Write pointer wr_addr:
  - Reset to 0.
  - On x_N_valid with dump_busy low: write x_N to RAM[wr_addr], then wr_addr++, wrapping DEPTH-1 -> 0.
- window_valid:
  - Set the cycle after a write at wr_addr == DEPTH-1.
  - Cleared only by reset.
- Dump acceptance: dump_req is accepted only in IDLE with window_valid = 1. Otherwise it is ignored: no beats, dump_busy stays 0.
- Snapshot contents:
  - The DEPTH samples written before the accept cycle.
  - A sample presented in the accept cycle is written and included. The RAM write completes that cycle, and the read start is the post-increment wr_addr, which is the oldest sample.
- While dump_busy = 1, x_N_valid samples are not written. wr_addr holds. drop_cnt increments, saturating.
- drop_cnt clears to 0 in the accept cycle and holds its value after the dump ends.
- RAM: simple dual-port, one write port and one read port, registered read with 1-cycle latency. A read-enable holds the read register while the output is stalled.
- FSM:
  - IDLE -> PRIME on accept. Latch rd_addr = next wr_addr and beat counter = 0.
  - PRIME: issue the first read. -> STREAM.
  - STREAM:
    - Present a beat. On m_valid && m_ready, advance rd_addr (mod DEPTH) and the counter, and issue the next read.
    - On the handshake with m_last = 1 -> IDLE.
- m_last = 1 exactly when counter == DEPTH-1 and m_valid = 1.
- Handshake rules:
  - Once m_valid = 1, m_valid, m_data and m_last hold until m_ready = 1.
  - m_valid never depends combinationally on m_ready.
- Reset mid-dump:
  - Next cycle: IDLE, m_valid = 0, dump_busy = 0, window_valid = 0, wr_addr = 0, drop_cnt = 0.
  - RAM contents are don't-care; no further beats are emitted.

## Timing
- Reset values: window_valid 0, dump_busy 0, m_valid 0, m_last 0, m_data 0, drop_cnt 0.
- Accept at cycle t:
  - dump_busy = 1 from t+1.
  - First m_valid = 1 at t+2.
- With m_ready held at 1: one beat per cycle, last beat at t+1+DEPTH.
- dump_busy falls the cycle after the m_last handshake. A new dump_req is accepted in that cycle or later.
- A dump_req coincident with the final m_last handshake is ignored.
- Backpressure: m_ready low for k cycles extends the dump by exactly k cycles; no beat is lost or duplicated.
- Writes resume in the cycle dump_busy reads 0.

## Test plan
- Reset, write 15 samples (DEPTH=16), pulse dump_req -> ignored; dump_busy stays 0, window_valid 0. Write a 16th -> window_valid = 1 next cycle.
- Write 1..20, dump with m_ready = 1 -> beats 5,6,...,20, first m_valid 2 cycles after accept, m_last only on 20, dump_busy low the following cycle.
- Write 1..16, then in the accept cycle present x_N = 17 -> beats 2..17.
- During a dump, present 5 samples -> drop_cnt = 5, wr_addr unchanged. A following dump reproduces the same window and clears drop_cnt in its accept cycle.
- Random m_ready (about 50%) over 3 back-to-back dumps -> every beat is held stable while stalled, exactly 16 beats per dump, and order matches the reference model.
- Assert reset at the 8th beat -> m_valid = 0 next cycle, no further beats, all outputs at reset values. After 16 new writes, a dump returns only the new samples.
